// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared state encoding, default widths and bank-select helper for
//           the data-RAM request controllers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_WAIT  = WAIT,
        S_RESP  = RESP
    } state_e;

    // The top address bit picks the bank.
    function automatic int bank_bit(input int addr_width);
        return addr_width - 1;
    endfunction

endpackage : mem_pkg

`default_nettype wire

// File: rtl/ram_req_ctrl.sv
// ============================================================================
// Module  : ram_req_ctrl
// Purpose : Single-outstanding load/store front end for data-RAM port A, with
//           read-latency wait and bank-range error responses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_req_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_BANKS  = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    generate
        if (!(NUM_BANKS == 1 || NUM_BANKS == 2)) begin : g_bad_num_banks
            $error("ram_req_ctrl: NUM_BANKS must be 1 or 2");
        end
        if (!(RD_LATENCY >= 1 && RD_LATENCY <= 3)) begin : g_bad_rd_latency
            $error("ram_req_ctrl: RD_LATENCY must be 1, 2 or 3");
        end
    endgenerate

    localparam int         BANK_BIT = bank_bit(ADDR_WIDTH);
    localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [DATA_WIDTH-1:0]   ram_data_q;
    logic                    ram_we_q;
    logic                    we_q;
    logic                    err_q;
    logic [1:0]              lat_cnt_q;

    logic                    accept_d;
    logic                    bank_ok_d;

    assign accept_d  = req_valid && req_ready_q && (state_q == S_IDLE);
    assign bank_ok_d = ({31'd0, req_addr[BANK_BIT]} < 32'(NUM_BANKS));

    // ram_we is decided at acceptance so the pulse lines up with ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            lat_cnt_q   <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept_d) begin
                        we_q        <= req_we;
                        err_q       <= !bank_ok_d;
                        ram_addr_q  <= req_addr;
                        ram_data_q  <= req_wdata;
                        ram_we_q    <= req_we && bank_ok_d;
                        req_ready_q <= 1'b0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ram_we_q <= 1'b0;
                    if (err_q || we_q) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= err_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        lat_cnt_q <= LAT_INIT;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        rsp_rdata_q <= ram_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    ram_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_we    = ram_we_q;

endmodule : ram_req_ctrl

`default_nettype wire

// File: tb/tb_ram_req_ctrl.sv
// ============================================================================
// Module  : tb_ram_req_ctrl
// Purpose : Scoreboard bench for ram_req_ctrl; DUT 0 is 1 bank / latency 1,
//           DUT 1 is 2 banks / latency 3, each with a behavioural RAM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_req_ctrl;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic [7:0]  lat;
    } rsp_t;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [9:0]  req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [9:0]  ram_addr  [2];
    logic [15:0] ram_data  [2];
    logic        ram_we    [2];
    logic [15:0] ram_q     [2];

    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];
    logic [15:0] p1a, p1b;

    rsp_t exp_q0[$], exp_q1[$];
    wr_t  wr_q0[$],  wr_q1[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc [2];
    logic busy    [2];
    logic prev_v  [2];
    rsp_t held    [2];
    int   n_rsp   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_req_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .NUM_BANKS(1), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .ram_addr(ram_addr[0]), .ram_data(ram_data[0]),
        .ram_we(ram_we[0]), .ram_q(ram_q[0])
    );

    ram_req_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .NUM_BANKS(2), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .ram_addr(ram_addr[1]), .ram_data(ram_data[1]),
        .ram_we(ram_we[1]), .ram_q(ram_q[1])
    );

    // Synchronous RAMs: latency 1 for DUT 0, latency 3 for DUT 1; preloaded while in reset.
    always @(posedge clk) begin
        if (rst[0] === 1'b1) begin
            mem0[10'h010] <= 16'h1111;
            mem0[10'h011] <= 16'h2222;
            mem0[10'h012] <= 16'h3333;
            mem0[10'h013] <= 16'h4444;
        end else if (ram_we[0]) begin
            mem0[ram_addr[0]] <= ram_data[0];
        end
        ram_q[0] <= mem0[ram_addr[0]];
    end

    always @(posedge clk) begin
        if (rst[1] === 1'b1) begin
            mem1[10'h3FF] <= 16'h1234;
        end else if (ram_we[1]) begin
            mem1[ram_addr[1]] <= ram_data[1];
        end
        p1a      <= mem1[ram_addr[1]];
        p1b      <= p1a;
        ram_q[1] <= p1b;
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic monitor(input int d);
        rsp_t e;
        wr_t  w;
        if (rst[d] !== 1'b0) begin
            busy[d]   = 1'b0;
            prev_v[d] = 1'b0;
            return;
        end
        if (busy[d]) chk("req_ready_while_busy", d, 32'(req_ready[d]), 32'd0);
        if (ram_we[d]) begin
            if ((d == 0 ? wr_q0.size() : wr_q1.size()) == 0) begin
                chk("unexpected_ram_we", d, 32'd1, 32'd0);
            end else begin
                w = (d == 0) ? wr_q0.pop_front() : wr_q1.pop_front();
                chk("ram_addr_on_we", d, 32'(ram_addr[d]), 32'(w.addr));
                chk("ram_data_on_we", d, 32'(ram_data[d]), 32'(w.data));
            end
        end
        if (rsp_valid[d] && !prev_v[d]) begin
            if (!busy[d] || (d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                chk("unexpected_rsp", d, 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(e.rdata));
                chk("rsp_err", d, 32'(rsp_err[d]), 32'(e.err));
                chk("rsp_latency", d, 32'(cyc - acc_cyc[d]), 32'(e.lat));
            end
            held[d].rdata = rsp_rdata[d];
            held[d].err   = rsp_err[d];
            n_rsp[d]++;
        end else if (rsp_valid[d]) begin
            chk("rsp_rdata_stable", d, 32'(rsp_rdata[d]), 32'(held[d].rdata));
            chk("rsp_err_stable", d, 32'(rsp_err[d]), 32'(held[d].err));
        end
        if (rsp_valid[d] && rsp_ready[d]) busy[d] = 1'b0;
        if (req_valid[d] && req_ready[d]) begin
            busy[d]    = 1'b1;
            acc_cyc[d] = cyc;
        end
        prev_v[d] = rsp_valid[d] && !rsp_ready[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor(d);
    end

    task automatic issue(input int d, input logic we, input logic [9:0] addr, input logic [15:0] wd,
                         input logic [15:0] erd, input logic eerr, input int elat);
        rsp_t e;
        wr_t  w;
        int   n;
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = 8'(elat);
        w.addr  = addr;
        w.data  = wd;
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        if (we && !eerr) begin
            if (d == 0) wr_q0.push_back(w); else wr_q1.push_back(w);
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready[d]) break;
            n++;
            if (n > 64) begin
                chk("accept_timeout", d, 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (busy[d] || (d == 0 ? exp_q0.size() : exp_q1.size()) != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("response_timeout", d, 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b1;
            busy[d]      = 1'b0;
            prev_v[d]    = 1'b0;
            n_rsp[d]     = 0;
            acc_cyc[d]   = 0;
            held[d]      = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_req_ready", d, 32'(req_ready[d]), 32'd0);
            chk("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            chk("reset_rsp_rdata", d, 32'(rsp_rdata[d]), 32'd0);
            chk("reset_rsp_err",   d, 32'(rsp_err[d]),   32'd0);
            chk("reset_ram_we",    d, 32'(ram_we[d]),    32'd0);
            chk("reset_ram_addr",  d, 32'(ram_addr[d]),  32'd0);
            chk("reset_ram_data",  d, 32'(ram_data[d]),  32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(posedge clk);
        #1;

        // Store then load on the single-bank, latency-1 instance.
        issue(0, 1'b1, 10'h005, 16'hBEEF, 16'h0000, 1'b0, 2);
        issue(0, 1'b0, 10'h005, 16'h0000, 16'hBEEF, 1'b0, 3);
        wait_done(0);

        // Unpopulated bank: error, no write, location 0x005 untouched.
        issue(0, 1'b0, 10'h200, 16'h0000, 16'h0000, 1'b1, 2);
        issue(0, 1'b1, 10'h205, 16'hDEAD, 16'h0000, 1'b1, 2);
        issue(0, 1'b0, 10'h005, 16'h0000, 16'hBEEF, 1'b0, 3);
        wait_done(0);

        // Backpressure with a competing request held meanwhile.
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 10'h010, 16'h0000, 16'h1111, 1'b0, 3);
        fork
            begin
                repeat (8) @(posedge clk);
                #1;
                rsp_ready[0] = 1'b1;
            end
            issue(0, 1'b1, 10'h011, 16'hCAFE, 16'h0000, 1'b0, 2);
        join
        wait_done(0);

        // Back-to-back loads with req_valid held.
        base = n_rsp[0];
        issue(0, 1'b0, 10'h010, 16'h0000, 16'h1111, 1'b0, 3);
        issue(0, 1'b0, 10'h011, 16'h0000, 16'hCAFE, 1'b0, 3);
        issue(0, 1'b0, 10'h012, 16'h0000, 16'h3333, 1'b0, 3);
        issue(0, 1'b0, 10'h013, 16'h0000, 16'h4444, 1'b0, 3);
        wait_done(0);
        chk("b2b_response_count", 0, 32'(n_rsp[0] - base), 32'd4);

        // Two banks, latency 3: top address is legal.
        issue(1, 1'b0, 10'h3FF, 16'h0000, 16'h1234, 1'b0, 5);
        issue(1, 1'b1, 10'h200, 16'h5A5A, 16'h0000, 1'b0, 2);
        issue(1, 1'b0, 10'h200, 16'h0000, 16'h5A5A, 1'b0, 5);
        wait_done(1);

        // Reset during WAIT: the pending load must never respond.
        issue(1, 1'b0, 10'h3FF, 16'h0000, 16'h1234, 1'b0, 5);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        exp_q1.delete();
        busy[1] = 1'b0;
        #1;
        chk("midreset_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("midreset_req_ready", 1, 32'(req_ready[1]), 32'd0);
        chk("midreset_ram_we",    1, 32'(ram_we[1]),    32'd0);
        chk("midreset_ram_addr",  1, 32'(ram_addr[1]),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 1, 32'(req_ready[1]), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        issue(1, 1'b0, 10'h3FF, 16'h0000, 16'h1234, 1'b0, 5);
        wait_done(1);

        chk("exp_q0_drained", 0, 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 1, 32'(exp_q1.size()), 32'd0);
        chk("wr_q0_drained",  0, 32'(wr_q0.size()),  32'd0);
        chk("wr_q1_drained",  1, 32'(wr_q1.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ram_req_ctrl

`default_nettype wire
